// File: rtl/uart_tx_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_feeder_pkg
//  Description : Shared types and constants for the UART transmit feeder:
//                byte type, default FIFO depth and the launch FSM states.
//  Revision    : 1.0  - initial release
// ============================================================================
package uart_tx_feeder_pkg;

    // Default number of buffered bytes in front of the transmitter.
    localparam int c_uart_fifo_depth = 16;

    typedef logic [7:0] byte_t;

    // Launch controller states. IDLE is all-zero so reset lands there.
    typedef enum logic [1:0] {
        FEED_IDLE     = 2'd0,
        FEED_LAUNCH   = 2'd1,
        FEED_WAIT_OK  = 2'd2,
        FEED_WAIT_NOK = 2'd3
    } feed_state_t;

    // Every state other than IDLE owns an in-flight byte.
    function automatic logic state_is_busy(input feed_state_t s);
        return (s != FEED_IDLE);
    endfunction

endpackage : uart_tx_feeder_pkg
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync_fifo
//  Description : Single-clock byte FIFO with occupancy counter and a sticky
//                overflow flag. No bypass: a byte written into an empty FIFO
//                is visible on head from the following cycle.
//  Ports       : clk, rst_n        clock / async active-low reset
//                push, push_data   write request and byte
//                pop               read request (ignored when empty)
//                clr_ovf           clears ovf (a same-cycle overflow wins)
//                head              byte at the read pointer
//                full, empty       level == DEPTH / level == 0
//                level             stored entries, 0..DEPTH
//                ovf               sticky, set by a push while full
//  Revision    : 1.0  - initial release
// ============================================================================
module uart_sync_fifo
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  byte_t       push_data,
    input  logic        pop,
    input  logic        clr_ovf,
    output byte_t       head,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level,
    output logic        ovf
);

    localparam logic [AW:0] c_full_level = (AW+1)'(DEPTH);

    byte_t          r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_level;
    logic           r_ovf;

    logic           w_full;
    logic           w_empty;
    logic           w_push_ok;
    logic           w_pop_ok;
    logic           w_overflow;

    assign w_full     = (r_level == c_full_level);
    assign w_empty    = (r_level == '0);
    // A push into a full FIFO is dropped even when a pop frees a slot in
    // the same cycle; the full flag is judged on the pre-edge level.
    assign w_push_ok  = push & ~w_full;
    assign w_pop_ok   = pop  & ~w_empty;
    assign w_overflow = push & w_full;

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
            // Overflow takes priority over a simultaneous clear.
            if (w_overflow) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = w_full;
    assign empty = w_empty;
    assign level = r_level;
    assign ovf   = r_ovf;

endmodule : uart_sync_fifo
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_feeder
//  Description : Byte buffer and launch controller in front of uart_tx.
//                Bytes are queued in a FIFO; one at a time is popped into
//                txd_in and launched with a one-cycle tx_start. The next
//                launch waits for tx_ok to rise and then fall.
//  Ports       : clk, rst_n        clock / async active-low reset
//                wr_en, wr_data    byte push from the bus side
//                tx_en             transmitter enable (shared with uart_tx)
//                tx_ok             uart_tx: high while the last bit is sent
//                clr_ovf           clears ovf_err
//                txd_in            byte to uart_tx, changes only on a pop
//                tx_start          one-cycle launch pulse
//                tx_busy           a byte is in flight
//                tx_done           one-cycle pulse on tx_ok falling
//                fifo_full/empty/level, ovf_err   buffer status
//  Revision    : 1.0  - initial release
// ============================================================================
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH = c_uart_fifo_depth,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        tx_en,
    input  logic        tx_ok,
    input  logic        clr_ovf,
    output logic [7:0]  txd_in,
    output logic        tx_start,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic [AW:0] fifo_level,
    output logic        ovf_err
);

    feed_state_t r_state;
    feed_state_t w_next_state;

    byte_t       r_txd;
    logic        r_tx_start;
    logic        r_tx_done;
    logic        r_tx_ok_q;

    logic        w_pop;
    logic        w_tx_ok_fall;
    logic        w_done;
    logic        w_launch;
    byte_t       w_head;
    logic        w_empty;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (w_pop),
        .clr_ovf   (clr_ovf),
        .head      (w_head),
        .full      (fifo_full),
        .empty     (w_empty),
        .level     (fifo_level),
        .ovf       (ovf_err)
    );

    // tx_ok falling edge relative to the previous cycle's sample.
    assign w_tx_ok_fall = r_tx_ok_q & ~tx_ok;
    // Completion only counts while still enabled; an abort is silent.
    assign w_done       = (r_state == FEED_WAIT_NOK) & tx_en & w_tx_ok_fall;
    // The launch pulse is registered out of the LAUNCH cycle, so it is seen
    // by uart_tx one cycle after the pop that loaded txd_in.
    assign w_launch     = (r_state == FEED_LAUNCH) & tx_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FEED_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            FEED_IDLE: begin
                if (tx_en && !w_empty) begin
                    w_next_state = FEED_LAUNCH;
                    w_pop        = 1'b1;
                end
            end
            FEED_LAUNCH: begin
                w_next_state = tx_en ? FEED_WAIT_OK : FEED_IDLE;
            end
            FEED_WAIT_OK: begin
                if (!tx_en) begin
                    w_next_state = FEED_IDLE;
                end else if (tx_ok) begin
                    w_next_state = FEED_WAIT_NOK;
                end
            end
            FEED_WAIT_NOK: begin
                if (!tx_en || !tx_ok) begin
                    w_next_state = FEED_IDLE;
                end
            end
            default: begin
                w_next_state = FEED_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txd      <= 8'h00;
            r_tx_start <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_ok_q  <= 1'b0;
        end else begin
            // txd_in is held from the pop until the next pop, which keeps it
            // stable for the whole transmission including the tx_ok window.
            if (w_pop) begin
                r_txd <= w_head;
            end
            r_tx_start <= w_launch;
            r_tx_done  <= w_done;
            r_tx_ok_q  <= tx_ok;
        end
    end

    assign txd_in     = r_txd;
    assign tx_start   = r_tx_start;
    assign tx_done    = r_tx_done;
    assign tx_busy    = state_is_busy(r_state);
    assign fifo_empty = w_empty;

endmodule : uart_tx_feeder
`default_nettype wire
